// File: rtl/edge_detection_pkg.sv
// Shared types and default geometry for the edge-detection pipeline.
package edge_detection_pkg;

  localparam int DEFAULT_COLUMNS     = 640;
  localparam int DEFAULT_ROWS        = 3;
  localparam int DEFAULT_PIXEL_DEPTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } frame_reader_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO with the head exposed combinationally; push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module pixel_skid_fifo #(
  parameter int P_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] head_o,
  output logic [1:0]         occupancy_o,
  output logic               empty_o
);

  logic [P_WIDTH-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;
  assign empty_o     = (count_q == 2'd0);

endmodule

// File: rtl/frame_buffer_reader.sv
// Raster-order read sequencer for frame_buffer: issues reads under credit
// control, absorbs the 1-cycle read latency and streams tagged pixels.
module frame_buffer_reader
  import edge_detection_pkg::*;
#(
  parameter int P_COLUMNS     = DEFAULT_COLUMNS,
  parameter int P_ROWS        = DEFAULT_ROWS,
  parameter int P_PIXEL_DEPTH = DEFAULT_PIXEL_DEPTH
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_START,
  output logic [$clog2(P_COLUMNS)-1:0] O_FB_COLUMN,
  output logic [$clog2(P_ROWS)-1:0]    O_FB_ROW,
  output logic                         O_FB_READ_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]     I_FB_PIXEL,
  output logic [P_PIXEL_DEPTH-1:0]     O_PIXEL,
  output logic [$clog2(P_COLUMNS)-1:0] O_COLUMN,
  output logic [$clog2(P_ROWS)-1:0]    O_ROW,
  output logic                         O_LAST,
  output logic                         O_VALID,
  input  logic                         I_READY,
  output logic                         O_BUSY,
  output logic                         O_DONE,
  output logic [1:0]                   O_DBG_STATE
);

  localparam int COL_W = $clog2(P_COLUMNS);
  localparam int ROW_W = $clog2(P_ROWS);
  localparam int TAG_W = P_PIXEL_DEPTH + COL_W + ROW_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P_COLUMNS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(P_ROWS - 1);

  // Handshake: a pixel transfers on any rising edge where O_VALID and I_READY
  // are both high; O_VALID never drops and the head never changes until then.

  frame_reader_state_t state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic                inflight_q;
  logic [COL_W-1:0]    tag_col_q;
  logic [ROW_W-1:0]    tag_row_q;
  logic                tag_last_q;

  logic                read_en;
  logic                pop;
  logic                at_last;
  logic                fifo_empty;
  logic [1:0]          fifo_occ;
  logic [TAG_W-1:0]    fifo_head;

  assign at_last = (col_q == LAST_COL) && (row_q == LAST_ROW);
  assign pop     = O_VALID && I_READY;

  // Credit: buffered plus in-flight pixels, less the one leaving now, stays below 2.
  assign read_en = (state_q == READ) &&
                   (({1'b0, fifo_occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_col_q  <= '0;
      tag_row_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= read_en;
      if (read_en) begin
        tag_col_q  <= col_q;
        tag_row_q  <= row_q;
        tag_last_q <= at_last;
        if (at_last) begin
          col_q <= '0;
          row_q <= '0;
        end else if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      case (state_q)
        IDLE:    if (I_START) state_q <= READ;
        READ:    if (read_en && at_last) state_q <= DRAIN;
        DRAIN:   if (!inflight_q && (fifo_empty || (fifo_occ == 2'd1 && pop))) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pixel_skid_fifo #(
    .P_WIDTH(TAG_W)
  ) u_fifo (
    .clk_i      (I_CLK),
    .reset_i    (I_RESET),
    .push_i     (inflight_q),
    .push_data_i({I_FB_PIXEL, tag_col_q, tag_row_q, tag_last_q}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .occupancy_o(fifo_occ),
    .empty_o    (fifo_empty)
  );

  assign O_FB_COLUMN      = col_q;
  assign O_FB_ROW         = row_q;
  assign O_FB_READ_ENABLE = read_en;
  assign {O_PIXEL, O_COLUMN, O_ROW, O_LAST} = fifo_head;
  assign O_VALID          = !fifo_empty;
  assign O_BUSY           = (state_q != IDLE);
  assign O_DONE           = (state_q == DONE);
  assign O_DBG_STATE      = state_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader with a registered frame_buffer model
// holding pixel = {row, column}.
module tb_frame_buffer_reader;

  localparam int COLS  = 640;
  localparam int ROWS  = 3;
  localparam int NPIX  = COLS * ROWS;
  localparam int TAG_W = 24 + 10 + 2 + 1;

  typedef struct {
    string name;
    int    ready_mode;      // 0: always ready, 1: toggle then 10-cycle stall
    bit    mid_start;
    int    exp_first_valid;
    int    exp_last_cycle;  // -1 when the vector does not pin it down
  } frame_vec_t;

  logic             clk = 1'b0;
  logic             I_RESET, I_START, I_READY;
  logic [9:0]       O_FB_COLUMN, O_COLUMN;
  logic [1:0]       O_FB_ROW, O_ROW, O_DBG_STATE;
  logic             O_FB_READ_ENABLE, O_LAST, O_VALID, O_BUSY, O_DONE;
  logic [23:0]      fb_pixel, O_PIXEL;

  logic [TAG_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  frame_vec_t       vecs[3];

  always #5 clk = ~clk;

  frame_buffer_reader dut (
    .I_CLK           (clk),
    .I_RESET         (I_RESET),
    .I_START         (I_START),
    .O_FB_COLUMN     (O_FB_COLUMN),
    .O_FB_ROW        (O_FB_ROW),
    .O_FB_READ_ENABLE(O_FB_READ_ENABLE),
    .I_FB_PIXEL      (fb_pixel),
    .O_PIXEL         (O_PIXEL),
    .O_COLUMN        (O_COLUMN),
    .O_ROW           (O_ROW),
    .O_LAST          (O_LAST),
    .O_VALID         (O_VALID),
    .I_READY         (I_READY),
    .O_BUSY          (O_BUSY),
    .O_DONE          (O_DONE),
    .O_DBG_STATE     (O_DBG_STATE)
  );

  function automatic logic [23:0] pix_of(input int col, input int row);
    return {12'(row), 12'(col)};
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input int col, input int row);
    logic last;
    last = (col == COLS - 1) && (row == ROWS - 1);
    return {pix_of(col, row), 10'(col), 2'(row), last};
  endfunction

  // Registered read port of the frame buffer.
  always @(posedge clk) begin
    if (O_FB_READ_ENABLE) fb_pixel <= pix_of(int'(O_FB_COLUMN), int'(O_FB_ROW));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [52:0] all_outputs();
    return {O_FB_COLUMN, O_FB_ROW, O_FB_READ_ENABLE, O_PIXEL, O_COLUMN, O_ROW,
            O_LAST, O_VALID, O_BUSY, O_DONE};
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c <= 200) return (c % 2) == 1;
    if (c <= 210) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_expected();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(tag_of(c, r));
  endtask

  task automatic run_frame(input frame_vec_t v);
    int c, n_xfer, first_valid, last_cycle, done_cycle, done_cnt, idle_cycle;
    int outstanding, max_out;
    bit finished, prev_stall, seen_row1, mid_done;
    logic [TAG_W-1:0] cur_tag, prev_tag, exp_tag;
    logic [11:0] prev_xy;
    n_xfer = 0; first_valid = -1; last_cycle = -1; done_cycle = -1; done_cnt = 0;
    idle_cycle = -1; outstanding = 0; max_out = 0; finished = 0; prev_stall = 0;
    seen_row1 = 0; mid_done = 0; prev_tag = '0; prev_xy = '0;
    fill_expected();
    @(negedge clk);
    I_START = 1'b1;
    I_READY = 1'b1;
    c = 0;
    while (!finished && c < 10000) begin
      c++;
      @(negedge clk);
      I_START = 1'b0;
      I_READY = ready_for(v.ready_mode, c);
      #1;
      cur_tag = {O_PIXEL, O_COLUMN, O_ROW, O_LAST};
      if (c == 1)
        check({v.name, ":first_read"}, {O_BUSY, O_FB_READ_ENABLE, O_FB_COLUMN, O_FB_ROW},
              {1'b1, 1'b1, 10'd0, 2'd0});
      if (prev_stall) check({v.name, ":stall_hold"}, {O_VALID, cur_tag}, {1'b1, prev_tag});
      if (O_VALID && first_valid < 0) first_valid = c;
      if (v.ready_mode == 1 && c == 210)
        check({v.name, ":stall_re_full"}, {O_FB_READ_ENABLE, O_VALID}, {1'b0, 1'b1});
      if (O_VALID && I_READY) begin
        check({v.name, ":xfer_expected"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_tag = exp_q.pop_front();
          check({v.name, ":xfer_tag"}, cur_tag, exp_tag);
        end
        if (O_ROW == 2'd1 && !seen_row1) begin
          seen_row1 = 1;
          check({v.name, ":row1_first_col"}, O_COLUMN, 10'd0);
          check({v.name, ":wrap_prev"}, prev_xy, {10'd639, 2'd0});
        end
        if (v.mid_start && !mid_done && O_COLUMN == 10'd320 && O_ROW == 2'd1) begin
          I_START = 1'b1;
          mid_done = 1;
        end
        prev_xy = {O_COLUMN, O_ROW};
        n_xfer++;
        last_cycle = c;
      end
      outstanding += int'(O_FB_READ_ENABLE) - int'(O_VALID && I_READY);
      if (outstanding > max_out) max_out = outstanding;
      if (O_DONE) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cnt > 0 && !O_BUSY) begin
        idle_cycle = c;
        finished = 1;
        check({v.name, ":idle_state"}, O_DBG_STATE, 2'd0);
      end
      prev_stall = O_VALID && !I_READY;
      prev_tag = cur_tag;
    end
    I_START = 1'b0;
    I_READY = 1'b1;
    check({v.name, ":frame_finished"}, finished, 1'b1);
    check({v.name, ":xfer_count"}, n_xfer, NPIX);
    check({v.name, ":queue_empty"}, exp_q.size(), 0);
    check({v.name, ":first_valid"}, first_valid, v.exp_first_valid);
    if (v.exp_last_cycle >= 0) check({v.name, ":last_cycle"}, last_cycle, v.exp_last_cycle);
    check({v.name, ":done_cycle"}, done_cycle, last_cycle + 1);
    check({v.name, ":done_count"}, done_cnt, 1);
    check({v.name, ":busy_fall"}, idle_cycle, last_cycle + 2);
    check({v.name, ":max_buffered_le2"}, max_out <= 2, 1'b1);
    check({v.name, ":row1_seen"}, seen_row1, 1'b1);
    if (v.mid_start) check({v.name, ":mid_start_applied"}, mid_done, 1'b1);
  endtask

  initial begin
    int guard;
    vecs[0] = '{name: "full_ready",   ready_mode: 0, mid_start: 0, exp_first_valid: 3, exp_last_cycle: NPIX + 2};
    vecs[1] = '{name: "backpressure", ready_mode: 1, mid_start: 0, exp_first_valid: 3, exp_last_cycle: -1};
    vecs[2] = '{name: "mid_start",    ready_mode: 0, mid_start: 1, exp_first_valid: 3, exp_last_cycle: NPIX + 2};

    // Reset with a simultaneous start: reset must win.
    I_RESET = 1'b1;
    I_START = 1'b1;
    I_READY = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", all_outputs(), '0);
    check("reset_state", O_DBG_STATE, 2'd0);
    @(negedge clk);
    I_RESET = 1'b0;
    I_START = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_outputs", all_outputs(), '0);
    check("idle_state", O_DBG_STATE, 2'd0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset mid-frame at (100,1) with the FIFO full.
    @(negedge clk);
    I_START = 1'b1;
    I_READY = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      I_START = 1'b0;
      #1;
      guard++;
    end while (!(O_VALID && O_COLUMN == 10'd100 && O_ROW == 2'd1) && guard < 5000);
    check("mid_reset_reached", guard < 5000, 1'b1);
    I_READY = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_reset_fifo_full", {O_VALID, O_FB_READ_ENABLE, O_BUSY}, {1'b1, 1'b0, 1'b1});
    @(negedge clk);
    I_RESET = 1'b1;
    @(negedge clk);
    I_RESET = 1'b0;
    #1;
    check("mid_reset_outputs", all_outputs(), '0);
    check("mid_reset_state", O_DBG_STATE, 2'd0);
    I_READY = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_reset_no_stale", {O_VALID, O_BUSY, O_FB_READ_ENABLE}, 3'b000);

    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
